// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data port. Byte-addressable,
//   little-endian RAM behind a valid/ready request and valid/ready response
//   handshake. A programmable number of wait states is inserted between
//   request accept and the RAM access. Byte/half/word loads are returned
//   sign- or zero-extended. Stores write only the addressed byte lanes.
//
//   Optional build macro: DMEM_ALIGN_CHECK_EN
//     defined     -> misaligned half/word accesses return rsp_err=1 and
//                    leave the RAM untouched
//     not defined -> rsp_err is always 0 and the low address bits are
//                    cleared so the access proceeds aligned
//
//   Ports
//     clk, reset        clock; synchronous active-high reset
//     req_valid/ready   request handshake (ready only in IDLE)
//     req_we            1 = store, 0 = load
//     req_addr          byte address, bits above ADDR_WIDTH ignored
//     req_size          00 byte, 01 half, 10 word, 11 treated as word
//     req_unsigned      1 = zero-extend loads
//     req_wdata         LSB-aligned store data
//     rsp_valid/ready   response handshake
//     rsp_rdata         extended load data, 0 for stores and errors
//     rsp_err           access rejected
//
//   state  | meaning
//   IDLE   | ready for a request
//   WAIT   | burning wait states
//   ACCESS | one-cycle RAM read/write
//   RESP   | response held until accepted

module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t state, state_next;

    logic [7:0]            mem [0:DEPTH-1];
    logic [3:0]            cnt;
    logic                  cap_we;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [1:0]            cap_size;
    logic                  cap_unsigned;
    logic [31:0]           cap_wdata;

    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] base, a1, a2, a3;
    logic [3:0]            lane_en;
    logic [31:0]           raw;
    logic [31:0]           load_data;

    // Address bits above the decoded range wrap and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        acc_err = ((cap_size == 2'b01) && cap_addr[0]) ||
                  (cap_size[1] && (cap_addr[1:0] != 2'b00));
        base    = cap_addr;
    end
`else
    always_comb begin
        acc_err = 1'b0;
        base    = cap_addr;
        if (cap_size == 2'b01) begin
            base[0] = 1'b0;
        end else if (cap_size[1]) begin
            base[1:0] = 2'b00;
        end
    end
`endif

    // Lane addresses wrap modulo the RAM depth by virtue of their width.
    assign a1 = base + ADDR_WIDTH'(1);
    assign a2 = base + ADDR_WIDTH'(2);
    assign a3 = base + ADDR_WIDTH'(3);

    always_comb begin
        lane_en = 4'b1111;
        case (cap_size)
            2'b00:   lane_en = 4'b0001;
            2'b01:   lane_en = 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    assign raw = {mem[a3], mem[a2], mem[a1], mem[base]};

    always_comb begin
        load_data = raw;
        case (cap_size)
            2'b00:   load_data = {{24{raw[7]  & ~cap_unsigned}}, raw[7:0]};
            2'b01:   load_data = {{16{raw[15] & ~cap_unsigned}}, raw[15:0]};
            default: load_data = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= 4'd0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            cap_we       <= 1'b0;
            cap_addr     <= '0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_wdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we       <= req_we;
                        cap_addr     <= req_addr[ADDR_WIDTH-1:0];
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_wdata    <= req_wdata;
                        cnt          <= 4'(WAIT_STATES);
                    end
                end
                WAIT: cnt <= cnt - 4'd1;
                ACCESS: begin
                    rsp_rdata <= (cap_we || acc_err) ? 32'd0 : load_data;
                    rsp_err   <= acc_err;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM is not reset; a reset coinciding with ACCESS suppresses the commit.
    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS && cap_we && !acc_err) begin
            if (lane_en[0]) mem[base] <= cap_wdata[7:0];
            if (lane_en[1]) mem[a1]   <= cap_wdata[15:8];
            if (lane_en[2]) mem[a2]   <= cap_wdata[23:16];
            if (lane_en[3]) mem[a3]   <= cap_wdata[31:24];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction; returns data, error flag and accept->valid latency.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input int stall,
                          output logic [31:0] rdata, output logic err, output int lat);
        logic [31:0] held;
        int guard;
        @(negedge clk);
        req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata; req_valid = 1'b1;
        rsp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk("accept_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        req_we = ~we; req_size = ~size; req_unsigned = ~uns;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        held = rsp_rdata;
        for (int k = 0; k < stall; k++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, held);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rdata = rsp_rdata;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_rdata", rsp_rdata, 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        vecs[0]  = '{1'b1, 32'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{1'b0, 32'h010, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b0, 32'h013, 2'b00, 1'b0, 32'h0,        32'hFFFFFFDE};
        vecs[3]  = '{1'b0, 32'h013, 2'b00, 1'b1, 32'h0,        32'h000000DE};
        vecs[4]  = '{1'b0, 32'h010, 2'b01, 1'b0, 32'h0,        32'hFFFFBEEF};
        vecs[5]  = '{1'b0, 32'h012, 2'b01, 1'b1, 32'h0,        32'h0000DEAD};
        vecs[6]  = '{1'b1, 32'h011, 2'b00, 1'b0, 32'hFFFFFF55, 32'h00000000};
        vecs[7]  = '{1'b0, 32'h010, 2'b10, 1'b0, 32'h0,        32'hDEAD55EF};
        vecs[8]  = '{1'b1, 32'h020, 2'b10, 1'b0, 32'h11223344, 32'h00000000};
        vecs[9]  = '{1'b1, 32'h020, 2'b01, 1'b0, 32'hA5A58001, 32'h00000000};
        vecs[10] = '{1'b0, 32'h020, 2'b11, 1'b1, 32'h0,        32'h11228001};
        vecs[11] = '{1'b0, 32'h021, 2'b00, 1'b0, 32'h0,        32'hFFFFFF80};
        vecs[12] = '{1'b1, 32'h3FC, 2'b10, 1'b0, 32'hCAFEF00D, 32'h00000000};
        vecs[13] = '{1'b0, 32'h3FF, 2'b00, 1'b0, 32'h0,        32'hFFFFFFCA};
        vecs[14] = '{1'b0, 32'h410, 2'b10, 1'b0, 32'h0,        32'hDEAD55EF};
        vecs[15] = '{1'b0, 32'h7FE, 2'b01, 1'b1, 32'h0,        32'h0000CAFE};

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_rsp_rdata", rsp_rdata, 32'd0);
        chk("idle_rsp_err", 32'(rsp_err), 32'd0);

        for (int i = 0; i < 16; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns,
                   vecs[i].wdata, 0, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'd0);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
        end

        // Response back-pressure: held three cycles with stable data.
        do_req(1'b0, 32'h010, 2'b10, 1'b0, 32'h0, 3, rd, er, lat);
        chk("stall_final_rdata", rd, 32'hDEAD55EF);
        chk("stall_latency", 32'(lat), 32'd4);

        // Reset during WAIT of a store: the store must not commit.
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h020; req_size = 2'b10;
        req_unsigned = 1'b0; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (4) @(negedge clk);
        chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        do_req(1'b0, 32'h020, 2'b10, 1'b0, 32'h0, 0, rd, er, lat);
        chk("rst_mid_prior_data", rd, 32'h11228001);

        // Misaligned store word at 0x12 and misaligned half load at 0x11.
        do_req(1'b1, 32'h012, 2'b10, 1'b0, 32'h0BADF00D, 0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_store_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h010, 2'b10, 1'b0, 32'h0, 0, rd, er, lat);
        chk("mis_store_unchanged", rd, 32'hDEAD55EF);
        do_req(1'b0, 32'h011, 2'b01, 1'b1, 32'h0, 0, rd, er, lat);
        chk("mis_load_err", 32'(er), 32'd1);
        chk("mis_load_rdata", rd, 32'd0);
`else
        chk("mis_store_err", 32'(er), 32'd0);
        do_req(1'b0, 32'h010, 2'b10, 1'b0, 32'h0, 0, rd, er, lat);
        chk("mis_store_aligned", rd, 32'h0BADF00D);
        do_req(1'b0, 32'h011, 2'b01, 1'b1, 32'h0, 0, rd, er, lat);
        chk("mis_load_err", 32'(er), 32'd0);
        chk("mis_load_rdata", rd, 32'h0000F00D);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
